// File: rtl/rns_eac_reduce_6.sv
// rns_eac_reduce_6: two-stage handshaked end-around-carry reduction of {cout,sum} mod 2^W-1.
// Define RNS_ZERO_NORM_EN to store an all-ones residue as 0 (unique zero representation).
module rns_eac_reduce_6 #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_cout,
    input  logic [W-1:0] in_sum,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    input  logic         clr_cnt,
    output logic [7:0]   eac_cnt
);
    logic         s1_v, s2_v, s1_c, s2_load, in_xfer, out_xfer;
    logic [W-1:0] s1_s, r, rn;
    logic [W:0]   t;
    assign s2_load   = s1_v && (!s2_v || out_ready);
    assign in_ready  = !s1_v || s2_load;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = s2_v && out_ready;
    assign out_valid = s2_v;
    // the second add cannot carry again: t[W] set implies t[W-1:0] is zero
    assign t = {1'b0, s1_s} + {{W{1'b0}}, s1_c};
    assign r = t[W-1:0] + {{(W-1){1'b0}}, t[W]};
`ifdef RNS_ZERO_NORM_EN
    assign rn = &r ? '0 : r;
`else
    assign rn = r;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s1_c    <= 1'b0;
            s1_s    <= '0;
            out_res <= '0;
            eac_cnt <= '0;
        end else begin
            if (in_xfer) begin
                s1_c <= in_cout;
                s1_s <= in_sum;
            end
            if (s2_load) out_res <= rn;
            s1_v    <= in_xfer ? 1'b1 : (s2_load ? 1'b0 : s1_v);
            s2_v    <= s2_load ? 1'b1 : (out_xfer ? 1'b0 : s2_v);
            eac_cnt <= clr_cnt ? 8'd0
                     : (in_xfer && in_cout && eac_cnt != 8'hff) ? eac_cnt + 8'd1 : eac_cnt;
        end
    end
endmodule

// File: tb/tb_rns_eac_reduce_6.sv
// tb_rns_eac_reduce_6: directed stimulus with a queue-based residue model checked every cycle.
module tb_rns_eac_reduce_6;
    logic       clk = 0, rst = 1, in_valid = 0, in_cout = 0, out_ready = 1, clr_cnt = 0;
    logic [5:0] in_sum = 0;
    logic       in_ready, out_valid;
    logic [5:0] out_res;
    logic [7:0] eac_cnt;
    int checks = 0, failures = 0;
    int q[$], log_q[$];
    int mcnt = 0, prev_res = 0;
    bit run = 0, prev_stall = 0;

    rns_eac_reduce_6 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_cout(in_cout), .in_sum(in_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .clr_cnt(clr_cnt), .eac_cnt(eac_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // residue of cout*64+sum modulo 63; zero is 63 unless it came from value 0
    function automatic int model(input int s, input int c);
        int v = c * 64 + s;
        int m = v % 63;
`ifdef RNS_ZERO_NORM_EN
        return m;
`else
        return (m == 0 && v != 0) ? 63 : m;
`endif
    endfunction

    always @(negedge clk) if (run) begin
        if (prev_stall) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_res", int'(out_res), prev_res);
        end
        if (out_valid) begin
            if (q.size() == 0) chk("valid_without_data", int'(out_valid), 0);
            else chk("out_res", int'(out_res), q[0]);
        end
        chk("eac_cnt", int'(eac_cnt), mcnt);
        if (rst) begin
            q.delete();
            mcnt = 0;
            prev_stall = 0;
        end else begin
            if (out_valid && out_ready && q.size() != 0) begin
                log_q.push_back(int'(out_res));
                void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(int'(in_sum), int'(in_cout)));
            mcnt = clr_cnt ? 0 : (in_valid && in_ready && in_cout && mcnt < 255) ? mcnt + 1 : mcnt;
            prev_stall = out_valid && !out_ready;
            prev_res = int'(out_res);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s, input int c);
        bit ok = 0;
        in_valid = 1;
        in_sum = 6'(s);
        in_cout = c[0];
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        cyc();
        in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        bit acc;
        int seq[5] = '{1, 2, 3, 4, 5};
        cyc();
        cyc();
        rst = 0;
        run = 1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_eac_cnt", int'(eac_cnt), 0);
        chk("rst_out_res", int'(out_res), 0);
        // latency: valid appears one edge after S1 loads
        send(10, 0);
        chk("lat_s1_only", int'(out_valid), 0);
        cyc();
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_res10", int'(out_res), 10);
        cyc();
        send(63, 1);
        chk("cnt_after_127", int'(eac_cnt), 1);
        cyc();
        chk("res_127", int'(out_res), 1);
        cyc();
        send(63, 0);
        cyc();
`ifdef RNS_ZERO_NORM_EN
        chk("res_63_norm", int'(out_res), 0);
`else
        chk("res_63_raw", int'(out_res), 63);
`endif
        send(0, 0);
        cyc();
        chk("res_zero", int'(out_res), 0);
        cyc();
        // backpressure stream
        log_q.delete();
        out_ready = 0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1;
            in_sum = 6'(seq[idx]);
            in_cout = 0;
            @(negedge clk);
            acc = in_ready;
            cyc();
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready_low", int'(in_ready), 0);
        out_ready = 1;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            in_sum = 6'(seq[idx]);
            @(negedge clk);
            acc = in_ready;
            cyc();
            if (acc) idx++;
        end
        in_valid = 0;
        repeat (4) cyc();
        chk("bp_count", log_q.size(), 5);
        for (int i = 0; i < 5; i++) chk("bp_order", (i < log_q.size()) ? log_q[i] : -1, i + 1);
        // saturation then clear-with-increment
        for (int i = 0; i < 300; i++) send(i % 64, 1);
        chk("cnt_sat", int'(eac_cnt), 255);
        clr_cnt = 1;
        send(5, 1);
        clr_cnt = 0;
        chk("cnt_clr_prio", int'(eac_cnt), 0);
        repeat (3) cyc();
        // reset with both stages full
        out_ready = 0;
        send(7, 0);
        send(8, 1);
        chk("full_out_valid", int'(out_valid), 1);
        chk("full_in_ready", int'(in_ready), 0);
        rst = 1;
        cyc();
        rst = 0;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_eac_cnt", int'(eac_cnt), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_no_valid", int'(out_valid), 0);
        end
        chk("drain_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rns_eac_reduce_6.md
RNS_EAC_REDUCE_6 -- requirements
Module: rns_eac_reduce_6

Interface
REQ-001 Parameter: W, default 6, residue width; the modulus is 2^W-1 (63 at the default).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream holds a valid {in_cout,in_sum}.
REQ-005 Port: in_ready  output  1  block accepts input this cycle.
REQ-006 Port: in_cout  input  1  carry-out of upstream 3+6-bit CLA adder.
REQ-007 Port: in_sum  input  W  sum bits of upstream adder.
REQ-008 Port: out_valid  output  1  out_res is valid.
REQ-009 Port: out_ready  input  1  downstream accepts out_res.
REQ-010 Port: out_res  output  W  residue of {in_cout,in_sum} mod 2^W-1.
REQ-011 Port: clr_cnt  input  1  synchronous clear of eac_cnt.
REQ-012 Port: eac_cnt  output  8  count of accepted inputs with in_cout=1, saturating at 255.

Function
REQ-013 Two-stage pipeline: S1 registers the raw input {in_cout,in_sum}; S2 registers the reduced residue; each stage has a valid flag (s1_v, s2_v).
REQ-014 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-015 s2_load = s1_v && (!s2_v || out_ready); S2 captures the reduction of S1 on s2_load.
REQ-016 in_ready = !s1_v || s2_load (combinational; a full pipeline with out_ready=1 accepts one input per cycle).
REQ-017 s1_v next = input transfer ? 1 : (s2_load ? 0 : s1_v); s2_v next = s2_load ? 1 : (output transfer ? 0 : s2_v).
REQ-018 Reduction: t = in_sum + in_cout (W+1 bits); r = t[W-1:0] + t[W] (end-around carry, W bits, cannot overflow again).
REQ-019 out_res = S2 register; out_valid = s2_v; latency 2 cycles from input transfer to out_valid with no stall.
REQ-020 While out_valid=1 and out_ready=0, out_res and out_valid hold stable; no data is dropped or duplicated.
REQ-021 Throughput is 1 result/cycle when out_ready stays high; bubbles on in_valid propagate as out_valid=0.
REQ-022 eac_cnt increments by 1 on each input transfer with in_cout=1, saturating at 255; clr_cnt takes priority over increment in the same cycle.
REQ-023 Boundary: in_sum=63, in_cout=1 (value 127) yields r=1; in_sum=0, in_cout=0 yields r=0.

Reset
REQ-024 On rst=1 at a clock edge: s1_v=0, s2_v=0, out_res=0, eac_cnt=0; in_ready=1 in the following cycle.
REQ-025 Reset mid-operation discards all in-flight data; no out_valid pulse follows the reset.
REQ-026 rst overrides clr_cnt and all transfers in the same cycle.

Configuration
REQ-027 Macro RNS_ZERO_NORM_EN: when defined, a reduced value of 2^W-1 (all ones) is stored in S2 as 0, giving a unique zero representation.
REQ-028 Without RNS_ZERO_NORM_EN, all-ones is passed through unchanged (double-zero representation, e.g. in_sum=63, in_cout=0 -> out_res=63).

Verification
REQ-029 Reset, then in_sum=10, in_cout=0, out_ready=1 -> out_res=10 with out_valid=1 exactly 2 cycles after transfer.
REQ-030 in_sum=63, in_cout=1 -> out_res=1; eac_cnt=1.
REQ-031 in_sum=63, in_cout=0 -> out_res=0 with RNS_ZERO_NORM_EN, 63 without.
REQ-032 Stream 5 inputs (1,2,3,4,5) with out_ready held 0 for 4 cycles -> in_ready drops after 2 accepted, then outputs 1..5 in order with no loss or duplication.
REQ-033 300 back-to-back inputs with in_cout=1 -> eac_cnt saturates at 255; clr_cnt pulse together with an in_cout=1 transfer -> eac_cnt=0.
REQ-034 Assert rst with both stages valid -> out_valid=0 next cycle, eac_cnt=0, in_ready=1.
